// File: rtl/text_render_pipe.sv
// Character-cell text renderer: font lookup, attribute/cursor/blink resolution and palette
// mapping in a fixed three-cycle pipeline kept aligned with the incoming sync/blank stream.
module text_render_pipe #(
    parameter int  CHAR_W       = 8,
    parameter int  CHAR_H       = 16,
    parameter int  CODE_W       = 8,
    parameter int  BLINK_FRAMES = 30,
    localparam int RW           = $clog2(CHAR_H),
    localparam int CW           = $clog2(CHAR_W),
    localparam int LATENCY      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 blank,
    input  logic [CODE_W-1:0]    char_code,
    input  logic [7:0]           attr,
    input  logic [CW-1:0]        col_px,
    input  logic [RW-1:0]        row_px,
    input  logic                 cursor_hit,
    output logic [CODE_W+RW-1:0] font_addr,
    input  logic [CHAR_W-1:0]    font_data,
    input  logic                 pal_we,
    input  logic [3:0]           pal_idx,
    input  logic [23:0]          pal_data,
    output logic [7:0]           r_out,
    output logic [7:0]           g_out,
    output logic [7:0]           b_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 blank_out
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Stage 1/2 side-band registers
    logic [CODE_W+RW-1:0] font_addr_reg;
    logic [7:0]           attr_s1_reg;
    logic [7:0]           attr_s2_reg;
    logic [CW-1:0]        col_s1_reg;
    logic [CW-1:0]        col_s2_reg;
    logic                 cur_s1_reg;
    logic                 cur_s2_reg;

    // Sync/blank delay lines; index k holds the value captured at edge E<k>
    logic [LATENCY:0]     hs_pipe_reg;
    logic [LATENCY:0]     vs_pipe_reg;
    logic [LATENCY:0]     bl_pipe_reg;

    // Stage 3/4 datapath
    logic [CW-1:0]        bit_sel;
    logic                 font_bit;
    logic                 pix_on;
    logic                 cursor_vis;
    logic [3:0]           idx_reg;
    logic [3:0]           idx_next;
    logic [23:0]          rgb_reg;
    logic [23:0]          rgb_next;

    // Blink timing
    logic                 vs_prev_reg;
    logic                 vs_rise;
    logic [FW-1:0]        frame_cnt_reg;
    logic [FW-1:0]        frame_cnt_next;
    logic                 blink_phase_reg;
    logic                 blink_phase_next;

    // Palette storage needs a reset image, so it lives in flops rather than RAM
    logic [15:0][23:0]    pal_entries;

    always_ff @(posedge clk) begin
        if (rst) begin
            font_addr_reg <= '0;
            attr_s1_reg   <= '0;
            attr_s2_reg   <= '0;
            col_s1_reg    <= '0;
            col_s2_reg    <= '0;
            cur_s1_reg    <= 1'b0;
            cur_s2_reg    <= 1'b0;
            hs_pipe_reg   <= '0;
            vs_pipe_reg   <= '0;
            bl_pipe_reg   <= '1;
            idx_reg       <= '0;
            rgb_reg       <= '0;
        end else begin
            font_addr_reg <= {char_code, row_px};
            attr_s1_reg   <= attr;
            attr_s2_reg   <= attr_s1_reg;
            col_s1_reg    <= col_px;
            col_s2_reg    <= col_s1_reg;
            cur_s1_reg    <= cursor_hit;
            cur_s2_reg    <= cur_s1_reg;
            hs_pipe_reg   <= {hs_pipe_reg[LATENCY-1:0], hsync};
            vs_pipe_reg   <= {vs_pipe_reg[LATENCY-1:0], vsync};
            bl_pipe_reg   <= {bl_pipe_reg[LATENCY-1:0], blank};
            idx_reg       <= idx_next;
            rgb_reg       <= rgb_next;
        end
    end

    // MSB of the font row is the leftmost pixel of the glyph
    assign bit_sel  = CW'(CHAR_W - 1) - col_s2_reg;
    assign font_bit = font_data[bit_sel];

    always_comb begin
        pix_on     = font_bit & ~(attr_s2_reg[7] & blink_phase_reg);
        cursor_vis = cur_s2_reg & ~blink_phase_reg;
        idx_next   = {1'b0, attr_s2_reg[6:4]};
        if (pix_on ^ cursor_vis) begin
            idx_next = attr_s2_reg[3:0];
        end
    end

    // Blanking is applied after the lookup so palette contents never leak out
    always_comb begin
        rgb_next = pal_entries[idx_reg];
        if (bl_pipe_reg[LATENCY-1]) begin
            rgb_next = '0;
        end
    end

    assign vs_rise = vs_pipe_reg[0] & ~vs_prev_reg;

    always_comb begin
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (vs_rise) begin
            if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_reg     <= 1'b0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            vs_prev_reg     <= vs_pipe_reg[0];
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pal
            localparam logic [7:0] GRAY = 8'(gi * 17);
            logic [23:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= {3{GRAY}};
                end else if (pal_we && (pal_idx == 4'(gi))) begin
                    entry_reg <= pal_data;
                end
            end
            assign pal_entries[gi] = entry_reg;
        end
    endgenerate

    assign font_addr = font_addr_reg;
    assign r_out     = rgb_reg[23:16];
    assign g_out     = rgb_reg[15:8];
    assign b_out     = rgb_reg[7:0];
    assign hsync_out = hs_pipe_reg[LATENCY];
    assign vsync_out = vs_pipe_reg[LATENCY];
    assign blank_out = bl_pipe_reg[LATENCY];

endmodule

// File: tb/tb_text_render_pipe.sv
// Bench for text_render_pipe: vector table, hand sequences for blink/palette/reset,
// and a randomized stream checked against a pixel-level reference model.
module tb_text_render_pipe;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync, blank;
    logic [7:0]  char_code;
    logic [7:0]  attr;
    logic [2:0]  col_px;
    logic [3:0]  row_px;
    logic        cursor_hit;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_data;
    logic [7:0]  r_out, g_out, b_out;
    logic        hsync_out, vsync_out, blank_out;
    logic [23:0] rgb_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_render_pipe #(
        .CHAR_W(8), .CHAR_H(16), .CODE_W(8), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank),
        .char_code(char_code), .attr(attr), .col_px(col_px), .row_px(row_px),
        .cursor_hit(cursor_hit), .font_addr(font_addr), .font_data(font_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
    );

    assign rgb_o = {r_out, g_out, b_out};

    typedef struct {
        logic [7:0] code;
        logic [3:0] row;
        logic [2:0] col;
        logic [7:0] attr;
        logic       cur;
        logic       blank;
        logic       hs;
        logic       vs;
    } pix_t;

    typedef struct {
        pix_t        p;
        logic [23:0] exp_rgb;
    } vec_t;

    // Font ROM contents: address {0x41,3} is the known test glyph row, 0x000 is empty
    function automatic logic [7:0] rom_f(input logic [11:0] a);
        logic [11:0] h;
        if (a == 12'h413) return 8'h80;
        h = (a * 12'd149) ^ {a[4:0], a[11:5]};
        return h[7:0] ^ h[11:4];
    endfunction

    // Synchronous external font ROM
    always @(posedge clk) font_data <= rom_f(font_addr);

    function automatic pix_t mk(input logic [7:0] code, input logic [3:0] row, input logic [2:0] col,
                                input logic [7:0] at, input logic cur, input logic bl, input logic hs);
        pix_t p;
        p.code = code; p.row = row; p.col = col; p.attr = at;
        p.cur = cur; p.blank = bl; p.hs = hs; p.vs = 1'b0;
        return p;
    endfunction

    task automatic drive(input pix_t p);
        char_code  = p.code;
        row_px     = p.row;
        col_px     = p.col;
        attr       = p.attr;
        cursor_hit = p.cur;
        blank      = p.blank;
        hsync      = p.hs;
        vsync      = p.vs;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic vs_pulse;
        vsync = 1'b1;
        repeat (2) tick;
        vsync = 1'b0;
        repeat (2) tick;
    endtask

    vec_t tbl[11];
    pix_t idle_p, lit_p;

    // Reference model state for the randomized stream
    pix_t        hist[$];
    int          phase_hist[$];
    logic [23:0] mpal[16];

    function automatic logic [23:0] model_rgb(input pix_t q, input int ph);
        logic [7:0] fr;
        logic       fbit, on, cv;
        logic [3:0] idx;
        fr   = rom_f({q.code, q.row});
        fbit = fr[7 - q.col];
        on   = fbit && !(q.attr[7] && ph != 0);
        cv   = q.cur && (ph == 0);
        idx  = (on ^ cv) ? q.attr[3:0] : {1'b0, q.attr[6:4]};
        return q.blank ? 24'h0 : mpal[idx];
    endfunction

    initial begin
        idle_p = mk(8'h41, 4'd3, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b0);
        lit_p  = mk(8'h41, 4'd3, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0);

        tbl[0]  = '{mk(8'h41, 4'd3, 3'd0, 8'h0F, 1'b0, 1'b0, 1'b0), 24'hFFFFFF};
        tbl[1]  = '{mk(8'h41, 4'd3, 3'd1, 8'h0F, 1'b0, 1'b0, 1'b1), 24'h000000};
        tbl[2]  = '{mk(8'h41, 4'd3, 3'd0, 8'h8F, 1'b0, 1'b0, 1'b0), 24'hFFFFFF};
        tbl[3]  = '{mk(8'h41, 4'd3, 3'd1, 8'h1F, 1'b0, 1'b0, 1'b1), 24'h111111};
        tbl[4]  = '{mk(8'h41, 4'd3, 3'd1, 8'h1F, 1'b1, 1'b0, 1'b0), 24'hFFFFFF};
        tbl[5]  = '{mk(8'h41, 4'd3, 3'd0, 8'h1F, 1'b1, 1'b0, 1'b0), 24'h111111};
        tbl[6]  = '{mk(8'h41, 4'd3, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b1), 24'h000000};
        tbl[7]  = '{mk(8'h41, 4'd3, 3'd0, 8'h75, 1'b0, 1'b0, 1'b1), 24'h555555};
        tbl[8]  = '{mk(8'h41, 4'd3, 3'd1, 8'h75, 1'b0, 1'b0, 1'b0), 24'h777777};
        tbl[9]  = '{mk(8'h41, 4'd3, 3'd0, 8'h3A, 1'b1, 1'b0, 1'b0), 24'h333333};
        tbl[10] = '{mk(8'h00, 4'd0, 3'd0, 8'h2C, 1'b0, 1'b0, 1'b1), 24'h222222};

        // Reset state with live, lit input and syncs high
        rst = 1'b1;
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;
        drive(lit_p);
        hsync = 1'b1;
        vsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("reset_rgb", rgb_o, 24'h0);
            chk("reset_blank", blank_out, 1'b1);
            chk("reset_hsync", hsync_out, 1'b0);
            chk("reset_vsync", vsync_out, 1'b0);
            chk("reset_addr", font_addr, 12'h0);
            $display("reset cycle %0d rgb=%h blank=%b addr=%h", i, rgb_o, blank_out, font_addr);
        end
        hsync = 1'b0;
        vsync = 1'b0;
        rst = 1'b0;

        // Vector table streamed back to back
        for (int c = 0; c < 14; c++) begin
            drive(c < 11 ? tbl[c].p : idle_p);
            tick;
            if (c < 11) chk("tbl_addr", font_addr, {tbl[c].p.code, tbl[c].p.row});
            if (c < 3) begin
                chk("startup_blank", blank_out, 1'b1);
                chk("startup_rgb", rgb_o, 24'h0);
            end else begin
                chk("tbl_rgb", rgb_o, tbl[c-3].exp_rgb);
                chk("tbl_blank", blank_out, tbl[c-3].p.blank);
                chk("tbl_hsync", hsync_out, tbl[c-3].p.hs);
                $display("vector %0d attr=%h col=%0d cur=%b rgb=%h", c - 3, tbl[c-3].p.attr,
                         tbl[c-3].p.col, tbl[c-3].p.cur, rgb_o);
            end
        end

        // Blink with BLINK_FRAMES=2 and cursor visibility per phase
        drive(mk(8'h41, 4'd3, 3'd0, 8'h8F, 1'b0, 1'b0, 1'b0));
        repeat (4) tick;
        chk("blink_ph0", rgb_o, 24'hFFFFFF);
        vs_pulse; vs_pulse;
        repeat (3) tick;
        chk("blink_off", rgb_o, 24'h000000);
        drive(mk(8'h41, 4'd3, 3'd1, 8'h1F, 1'b1, 1'b0, 1'b0));
        repeat (4) tick;
        chk("cursor_ph1", rgb_o, 24'h111111);
        vs_pulse; vs_pulse;
        repeat (3) tick;
        chk("cursor_ph0", rgb_o, 24'hFFFFFF);
        drive(mk(8'h41, 4'd3, 3'd0, 8'h8F, 1'b0, 1'b0, 1'b0));
        repeat (4) tick;
        chk("blink_on", rgb_o, 24'hFFFFFF);
        $display("blink sequence rgb=%h", rgb_o);

        // Palette write colliding with a lookup of the same entry
        drive(lit_p);
        repeat (4) tick;
        chk("pal_pre", rgb_o, 24'hFFFFFF);
        pal_we = 1'b1; pal_idx = 4'd15; pal_data = 24'h123456;
        tick;
        pal_we = 1'b0;
        chk("pal_old", rgb_o, 24'hFFFFFF);
        tick;
        chk("pal_new", rgb_o, 24'h123456);
        $display("palette write idx=15 rgb=%h", rgb_o);

        // Mid-stream reset with one frame edge already counted
        vs_pulse;
        rst = 1'b1;
        tick;
        chk("midrst_blank", blank_out, 1'b1);
        chk("midrst_rgb", rgb_o, 24'h0);
        chk("midrst_addr", font_addr, 12'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("midrst_flush_blank", blank_out, 1'b1);
            chk("midrst_flush_rgb", rgb_o, 24'h0);
        end
        tick;
        chk("midrst_pal", rgb_o, 24'hFFFFFF);
        chk("midrst_unblank", blank_out, 1'b0);
        drive(mk(8'h41, 4'd3, 3'd0, 8'h8F, 1'b0, 1'b0, 1'b0));
        vs_pulse;
        repeat (3) tick;
        chk("midrst_blink1", rgb_o, 24'hFFFFFF);
        vs_pulse;
        repeat (3) tick;
        chk("midrst_blink2", rgb_o, 24'h000000);
        $display("mid-stream reset rgb=%h", rgb_o);

        // Randomized stream against the reference model
        rst = 1'b1;
        drive(idle_p);
        repeat (2) tick;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mpal[i] = {3{8'(i * 17)}};
        begin
            int   rises;
            logic vs_prev_in;
            logic vs_cur;
            rises = 0;
            vs_prev_in = 1'b0;
            vs_cur = 1'b0;
            for (int c = 0; c < 600; c++) begin
                pix_t p;
                logic        we;
                logic [3:0]  widx;
                logic [23:0] wdata;
                if ($urandom_range(0, 11) == 0) vs_cur = ~vs_cur;
                p.code  = 8'($urandom_range(0, 255));
                p.row   = 4'($urandom_range(0, 15));
                p.col   = 3'($urandom_range(0, 7));
                p.attr  = 8'($urandom_range(0, 255));
                p.cur   = ($urandom_range(0, 3) == 0);
                p.blank = ($urandom_range(0, 4) == 0);
                p.hs    = 1'($urandom_range(0, 1));
                p.vs    = vs_cur;
                we      = ($urandom_range(0, 7) == 0);
                widx    = 4'($urandom_range(0, 15));
                wdata   = 24'($urandom);
                if (p.vs && !vs_prev_in) rises++;
                vs_prev_in = p.vs;
                hist.push_back(p);
                phase_hist.push_back((rises / BF) % 2);
                drive(p);
                pal_we = we; pal_idx = widx; pal_data = wdata;
                tick;
                chk("rnd_addr", font_addr, {p.code, p.row});
                if (c >= 3) begin
                    logic [23:0] e;
                    e = model_rgb(hist[c-3], phase_hist[c-3]);
                    chk("rnd_rgb", rgb_o, e);
                    chk("rnd_blank", blank_out, hist[c-3].blank);
                    chk("rnd_hsync", hsync_out, hist[c-3].hs);
                    chk("rnd_vsync", vsync_out, hist[c-3].vs);
                    $display("rnd %0d attr=%h blank=%b phase=%0d rgb=%h exp=%h", c - 3,
                             hist[c-3].attr, hist[c-3].blank, phase_hist[c-3], rgb_o, e);
                end else begin
                    chk("rnd_start_blank", blank_out, 1'b1);
                    chk("rnd_start_rgb", rgb_o, 24'h0);
                end
                if (we) mpal[widx] = wdata;
            end
        end
        pal_we = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
